bcd_timer_counter: RTL and testbench
====================================

// Module: bcd_timer_counter
// PURPOSE
//  Parametrised multi-digit BCD up/down counter; the core of the digital timer display path.
//  Counts 0..MAX_VALUE, either direction, with parallel load, clock enable, wrap/hold mode.
//  Registers a terminal-count pulse for cascading into minute/hour stages.
//  count feeds seven-segment decoders directly, one nibble per digit.
// PARAMETERS
//  DIGITS     2   number of BCD digits; count width = 4*DIGITS; legal 1..6
//  MAX_VALUE  99  terminal value, decimal; legal 1..(10**DIGITS)-1
// PORTS
//  clk       in   1          clock, rising edge
//  reset     in   1          asynchronous, active-low reset
//  en        in   1          count enable; one step per clk while high
//  up_dn     in   1          1 = count up, 0 = count down; sampled when en=1
//  wrap_en   in   1          1 = wrap at boundary, 0 = hold at boundary
//  load      in   1          synchronous parallel load strobe
//  load_val  in   4*DIGITS   BCD value for load; digit 0 in [3:0]
//  count     out  4*DIGITS   current BCD value; digit 0 in [3:0]
//  tc        out  1          one-cycle pulse: enabled step hit the boundary
//  load_err  out  1          one-cycle pulse: load_val invalid, MAX_VALUE loaded instead
// BEHAVIOUR
//  Reset (reset=0, any time, incl. mid-count or mid-load): count=0, tc=0, load_err=0, immediately.
//  All outputs are registered; count, tc and load_err update on the same clk edge.
//  Priority per edge: load > en > hold. load with en=1: load wins, no step, tc=0.
//  Load: if every nibble <= 9 and value <= MAX_VALUE: count <= load_val, load_err=0.
//    Otherwise: count <= MAX_VALUE (BCD), load_err=1 for one cycle.
//  Up step (en=1, up_dn=1):
//    count < MAX_VALUE: count+1 in BCD; digit at 9 -> 0 with carry into next digit.
//    count == MAX_VALUE: wrap_en=1 -> count=0; wrap_en=0 -> hold MAX_VALUE. tc=1 in both cases.
//  Down step (en=1, up_dn=0):
//    count > 0: count-1 in BCD; digit at 0 -> 9 with borrow into next digit.
//    count == 0: wrap_en=1 -> count=MAX_VALUE; wrap_en=0 -> hold 0. tc=1 in both cases.
//  tc=1 only on the edge that applies a boundary step. A held counter re-asserts tc on every
//    enabled step while stuck at the boundary: a continuous pulse train, not a single pulse.
//  en=0 and load=0: count holds; tc=0, load_err=0.
//  Direction change mid-count takes effect on the next enabled edge with no dead cycle.
//  Counter never leaves 0..MAX_VALUE and never holds a non-BCD nibble.
//  Latency: one clk from en/load sampled to new count visible.
//  Comparisons against MAX_VALUE use a BCD constant derived from the parameter at elaboration.
// TESTING
//  Defaults: reset low, then en=1, up_dn=1, wrap_en=1 for 100 clks
//    -> count 00,01..09,10..99,00; tc=1 only on the 99->00 edge.
//  Defaults: load 25, then down-count 26 clks
//    -> 24..00, then 99; tc=1 on the 00->99 edge only.
//  wrap_en=0, count=99, en=1 up for 3 clks -> count stays 99; tc=1 on all 3 clks.
//  load_val=0x9A (bad nibble) -> count=99, load_err=1 for 1 clk.
//  DIGITS=3, MAX_VALUE=599, load 0x600 -> count 0x599, load_err=1.
//  Mid-count at count=47: reset pulsed low between edges -> count=00 at once.
//    Counting resumes 01 on the first edge after release.
//  load=1 and en=1 together, load_val=0x12 -> count=12, tc=0.
//  DIGITS=3, MAX_VALUE=599: count 0x199 up 1 clk -> 0x200 (multi-digit carry).

Source files
------------

// File: rtl/bcd_timer_counter.sv
// Multi-digit BCD up/down counter with parallel load, wrap/hold boundary mode
// and registered terminal-count / load-error pulses for cascading timer stages.
module bcd_timer_counter #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned MAX_VALUE = 99
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  en,
  input  logic                  up_dn,
  input  logic                  wrap_en,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  output logic [4*DIGITS-1:0]   count,
  output logic                  tc,
  output logic                  load_err
);

  localparam int unsigned W = 4 * DIGITS;

  // Decimal-to-BCD conversion, evaluated only at elaboration for the terminal value.
  function automatic logic [W-1:0] to_bcd(input int unsigned value);
    logic [W-1:0] res;
    int unsigned  rem;
    res = {W{1'b0}};
    rem = value;
    for (int i = 0; i < int'(DIGITS); i++) begin
      res[4*i +: 4] = 4'(rem % 32'd10);
      rem           = rem / 32'd10;
    end
    return res;
  endfunction

  // True when every nibble holds a decimal digit.
  function automatic logic all_digits_valid(input logic [W-1:0] value);
    logic ok;
    ok = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (value[4*i +: 4] > 4'd9) begin
        ok = 1'b0;
      end else begin
        ok = ok;
      end
    end
    return ok;
  endfunction

  // BCD increment with ripple carry; the caller guarantees value < MAX_BCD.
  function automatic logic [W-1:0] bcd_inc(input logic [W-1:0] value);
    logic [W-1:0] res;
    logic [3:0]   dig;
    logic         carry;
    res   = value;
    carry = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = value[4*i +: 4];
      if (carry) begin
        if (dig >= 4'd9) begin
          dig = 4'd0;
        end else begin
          dig   = dig + 4'd1;
          carry = 1'b0;
        end
      end else begin
        dig = dig;
      end
      res[4*i +: 4] = dig;
    end
    return res;
  endfunction

  // BCD decrement with ripple borrow; the caller guarantees value > 0.
  function automatic logic [W-1:0] bcd_dec(input logic [W-1:0] value);
    logic [W-1:0] res;
    logic [3:0]   dig;
    logic         borrow;
    res    = value;
    borrow = 1'b1;
    for (int i = 0; i < int'(DIGITS); i++) begin
      dig = value[4*i +: 4];
      if (borrow) begin
        if (dig == 4'd0) begin
          dig = 4'd9;
        end else begin
          dig    = dig - 4'd1;
          borrow = 1'b0;
        end
      end else begin
        dig = dig;
      end
      res[4*i +: 4] = dig;
    end
    return res;
  endfunction

  localparam logic [W-1:0] MAX_BCD  = to_bcd(MAX_VALUE);
  localparam logic [W-1:0] ZERO_BCD = {W{1'b0}};

  logic [W-1:0] count_r;
  logic         tc_r;
  logic         load_err_r;

  logic [W-1:0] count_nxt_s;
  logic         tc_nxt_s;
  logic         load_err_nxt_s;
  logic         load_ok_s;
  logic         at_max_s;
  logic         at_zero_s;

  // Valid BCD vectors order the same as their binary encodings, so a plain compare suffices.
  assign load_ok_s = all_digits_valid(load_val) && (load_val <= MAX_BCD);
  assign at_max_s  = (count_r >= MAX_BCD);
  assign at_zero_s = (count_r == ZERO_BCD);

  // Next-state selection: load has priority over a counting step, otherwise hold.
  always_comb begin
    count_nxt_s    = count_r;
    tc_nxt_s       = 1'b0;
    load_err_nxt_s = 1'b0;
    if (load) begin
      if (load_ok_s) begin
        count_nxt_s = load_val;
      end else begin
        count_nxt_s    = MAX_BCD;
        load_err_nxt_s = 1'b1;
      end
    end else if (en) begin
      case (up_dn)
        1'b1: begin
          if (at_max_s) begin
            tc_nxt_s    = 1'b1;
            count_nxt_s = wrap_en ? ZERO_BCD : MAX_BCD;
          end else begin
            count_nxt_s = bcd_inc(count_r);
          end
        end
        1'b0: begin
          if (at_zero_s) begin
            tc_nxt_s    = 1'b1;
            count_nxt_s = wrap_en ? MAX_BCD : ZERO_BCD;
          end else begin
            count_nxt_s = bcd_dec(count_r);
          end
        end
        default: begin
          count_nxt_s = count_r;
        end
      endcase
    end else begin
      count_nxt_s = count_r;
    end
  end

  // Output registers; reset clears everything immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_r    <= ZERO_BCD;
      tc_r       <= 1'b0;
      load_err_r <= 1'b0;
    end else begin
      count_r    <= count_nxt_s;
      tc_r       <= tc_nxt_s;
      load_err_r <= load_err_nxt_s;
    end
  end

  assign count    = count_r;
  assign tc       = tc_r;
  assign load_err = load_err_r;

endmodule

// File: tb/tb_bcd_timer_counter.sv
// Directed self-checking bench for bcd_timer_counter: a 2-digit/99 instance and
// a 3-digit/599 instance, checked with immediate assertions after each edge.
module tb_bcd_timer_counter;

  logic        clk;
  logic        reset;

  logic        a_en, a_up_dn, a_wrap_en, a_load;
  logic [7:0]  a_load_val;
  logic [7:0]  a_count;
  logic        a_tc, a_load_err;

  logic        b_en, b_up_dn, b_wrap_en, b_load;
  logic [11:0] b_load_val;
  logic [11:0] b_count;
  logic        b_tc, b_load_err;

  int total;
  int bad;

  bcd_timer_counter #(.DIGITS(2), .MAX_VALUE(99)) dut_a (
    .clk(clk), .reset(reset), .en(a_en), .up_dn(a_up_dn), .wrap_en(a_wrap_en),
    .load(a_load), .load_val(a_load_val), .count(a_count), .tc(a_tc),
    .load_err(a_load_err)
  );

  bcd_timer_counter #(.DIGITS(3), .MAX_VALUE(599)) dut_b (
    .clk(clk), .reset(reset), .en(b_en), .up_dn(b_up_dn), .wrap_en(b_wrap_en),
    .load(b_load), .load_val(b_load_val), .count(b_count), .tc(b_tc),
    .load_err(b_load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bcd2(input int v);
    logic [7:0] r;
    r = {4'((v / 10) % 10), 4'(v % 10)};
    return r;
  endfunction

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    a_en = 1'b0; a_up_dn = 1'b1; a_wrap_en = 1'b1; a_load = 1'b0; a_load_val = 8'h00;
    b_en = 1'b0; b_up_dn = 1'b1; b_wrap_en = 1'b1; b_load = 1'b0; b_load_val = 12'h000;

    #12;
    chk("reset_count", {4'h0, a_count}, 12'h000);
    chk("reset_tc", {11'd0, a_tc}, 12'h000);
    chk("reset_err", {11'd0, a_load_err}, 12'h000);
    chk("reset_b_count", b_count, 12'h000);

    // Full up-count with wrap
    reset = 1'b1;
    a_en = 1'b1; a_up_dn = 1'b1; a_wrap_en = 1'b1;
    for (int i = 1; i <= 100; i++) begin
      step();
      chk("up_count", {4'h0, a_count}, {4'h0, bcd2(i % 100)});
      chk("up_tc", {11'd0, a_tc}, {11'd0, (i == 100)});
    end

    // Load 25 then count down through the wrap
    a_en = 1'b0; a_load = 1'b1; a_load_val = 8'h25;
    step();
    chk("load25_count", {4'h0, a_count}, 12'h025);
    chk("load25_err", {11'd0, a_load_err}, 12'h000);
    chk("load25_tc", {11'd0, a_tc}, 12'h000);
    a_load = 1'b0; a_en = 1'b1; a_up_dn = 1'b0;
    for (int i = 1; i <= 26; i++) begin
      step();
      chk("dn_count", {4'h0, a_count}, {4'h0, (i <= 25) ? bcd2(25 - i) : 8'h99});
      chk("dn_tc", {11'd0, a_tc}, {11'd0, (i == 26)});
    end

    // Hold at max: tc pulse train
    a_wrap_en = 1'b0; a_up_dn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_max_count", {4'h0, a_count}, 12'h099);
      chk("hold_max_tc", {11'd0, a_tc}, 12'h001);
    end

    // Bad nibble load
    a_en = 1'b0; a_load = 1'b1; a_load_val = 8'h9A;
    step();
    chk("bad_load_count", {4'h0, a_count}, 12'h099);
    chk("bad_load_err", {11'd0, a_load_err}, 12'h001);
    chk("bad_load_tc", {11'd0, a_tc}, 12'h000);
    a_load = 1'b0;
    step();
    chk("err_pulse_end", {11'd0, a_load_err}, 12'h000);
    chk("idle_hold", {4'h0, a_count}, 12'h099);

    // Load beats enable
    a_load = 1'b1; a_en = 1'b1; a_up_dn = 1'b1; a_load_val = 8'h12;
    step();
    chk("load_pri_count", {4'h0, a_count}, 12'h012);
    chk("load_pri_tc", {11'd0, a_tc}, 12'h000);
    chk("load_pri_err", {11'd0, a_load_err}, 12'h000);
    a_load = 1'b0; a_en = 1'b0;
    step();
    chk("en0_hold", {4'h0, a_count}, 12'h012);

    // Reset between edges mid-count
    a_load = 1'b1; a_load_val = 8'h46;
    step();
    a_load = 1'b0; a_en = 1'b1; a_up_dn = 1'b1; a_wrap_en = 1'b1;
    step();
    chk("pre_reset_count", {4'h0, a_count}, 12'h047);
    reset = 1'b0;
    #2;
    chk("async_reset_count", {4'h0, a_count}, 12'h000);
    chk("async_reset_tc", {11'd0, a_tc}, 12'h000);
    #1;
    reset = 1'b1;
    step();
    chk("resume_count", {4'h0, a_count}, 12'h001);

    // Direction change without dead cycle, then down-wrap
    a_up_dn = 1'b0;
    step();
    chk("dir_change_count", {4'h0, a_count}, 12'h000);
    chk("dir_change_tc", {11'd0, a_tc}, 12'h000);
    step();
    chk("dn_wrap_count", {4'h0, a_count}, 12'h099);
    chk("dn_wrap_tc", {11'd0, a_tc}, 12'h001);

    // Hold at zero going down
    a_en = 1'b0; a_load = 1'b1; a_load_val = 8'h00;
    step();
    a_load = 1'b0; a_en = 1'b1; a_wrap_en = 1'b0; a_up_dn = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("hold_zero_count", {4'h0, a_count}, 12'h000);
      chk("hold_zero_tc", {11'd0, a_tc}, 12'h001);
    end
    a_en = 1'b0;

    // Three-digit instance, MAX_VALUE=599
    b_load = 1'b1; b_load_val = 12'h600;
    step();
    chk("b_over_load_count", b_count, 12'h599);
    chk("b_over_load_err", {11'd0, b_load_err}, 12'h001);
    b_load_val = 12'h5A0;
    step();
    chk("b_nibble_load_count", b_count, 12'h599);
    chk("b_nibble_load_err", {11'd0, b_load_err}, 12'h001);
    b_load_val = 12'h199;
    step();
    chk("b_load199_count", b_count, 12'h199);
    chk("b_load199_err", {11'd0, b_load_err}, 12'h000);
    b_load = 1'b0; b_en = 1'b1; b_up_dn = 1'b1; b_wrap_en = 1'b1;
    step();
    chk("b_carry_count", b_count, 12'h200);
    chk("b_carry_tc", {11'd0, b_tc}, 12'h000);
    b_en = 1'b0; b_load = 1'b1; b_load_val = 12'h599;
    step();
    chk("b_load599_err", {11'd0, b_load_err}, 12'h000);
    b_load = 1'b0; b_en = 1'b1;
    step();
    chk("b_up_wrap_count", b_count, 12'h000);
    chk("b_up_wrap_tc", {11'd0, b_tc}, 12'h001);
    b_up_dn = 1'b0;
    step();
    chk("b_dn_wrap_count", b_count, 12'h599);
    chk("b_dn_wrap_tc", {11'd0, b_tc}, 12'h001);
    step();
    chk("b_dn_step_count", b_count, 12'h598);
    b_en = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
